// File: rtl/pipe_pkg.sv
// Shared types and constants for the ID/EX pipeline slice: the packed decoder
// control word, the bubble value and the ALU operation encodings.
package pipe_pkg;

  typedef struct packed {
    logic [1:0] memtoreg;
    logic       memwrite;
    logic       branch;
    logic [2:0] alu_ctrl;
    logic       alu_src;
    logic       regdst;
    logic       regwrite;
    logic       jump;
    logic       mem_read;
  } id_ctrl_t;

  localparam int CTRL_W = 12;

  localparam id_ctrl_t CTRL_BUBBLE = '0;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // rt is a true source operand unless the immediate replaces it, except that
  // stores and branches always read rt.
  function automatic logic ctrl_uses_rt(input logic alu_src, input logic memwrite,
                                        input logic branch);
    return ~alu_src | memwrite | branch;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard compare between the load sitting in EX and
// the instruction currently in ID.
module load_use_detect
  import pipe_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              i_ex_valid,
  input  logic              i_ex_mem_read,
  input  logic [REG_AW-1:0] i_ex_rt,
  input  logic              i_id_valid,
  input  logic              i_id_alu_src,
  input  logic              i_id_memwrite,
  input  logic              i_id_branch,
  input  logic [REG_AW-1:0] i_id_rs,
  input  logic [REG_AW-1:0] i_id_rt,
  output logic              o_hazard
);

  logic w_use_rt;
  logic w_rs_match;
  logic w_rt_match;
  logic w_load_in_ex;

  assign w_use_rt     = ctrl_uses_rt(i_id_alu_src, i_id_memwrite, i_id_branch);
  // A load into r0 never produces a value anyone can depend on.
  assign w_load_in_ex = i_ex_valid & i_ex_mem_read & (i_ex_rt != '0);
  assign w_rs_match   = (i_ex_rt == i_id_rs);
  assign w_rt_match   = w_use_rt & (i_ex_rt == i_id_rt);
  assign o_hazard     = w_load_in_ex & i_id_valid & (w_rs_match | w_rt_match);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall and flush bubble insertion.
// Optional saturating perf counters are enabled by defining ID_EX_PERF_CNT_EN.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid_i,
  input  logic [11:0]       id_ctrl_i,
  input  logic [DATA_W-1:0] id_pc4_i,
  input  logic [DATA_W-1:0] id_rs_data_i,
  input  logic [DATA_W-1:0] id_rt_data_i,
  input  logic [DATA_W-1:0] id_imm_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              flush_i,
  input  logic              hold_i,
  output logic              stall_o,
  output logic              ex_valid_o,
  output logic [11:0]       ex_ctrl_o,
  output logic [DATA_W-1:0] ex_pc4_o,
  output logic [DATA_W-1:0] ex_rs_data_o,
  output logic [DATA_W-1:0] ex_rt_data_o,
  output logic [DATA_W-1:0] ex_imm_o,
  output logic [REG_AW-1:0] ex_rs_o,
  output logic [REG_AW-1:0] ex_rt_o,
  output logic [REG_AW-1:0] ex_rd_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  id_ctrl_t          w_id_ctrl;
  logic              w_hazard;
  logic              w_bubble;

  logic              r_ex_valid;
  id_ctrl_t          r_ex_ctrl;
  logic [DATA_W-1:0] r_ex_pc4;
  logic [DATA_W-1:0] r_ex_rs_data;
  logic [DATA_W-1:0] r_ex_rt_data;
  logic [DATA_W-1:0] r_ex_imm;
  logic [REG_AW-1:0] r_ex_rs;
  logic [REG_AW-1:0] r_ex_rt;
  logic [REG_AW-1:0] r_ex_rd;

  assign w_id_ctrl = id_ctrl_t'(id_ctrl_i);

  load_use_detect #(
    .REG_AW(REG_AW)
  ) u_load_use_detect (
    .i_ex_valid   (r_ex_valid),
    .i_ex_mem_read(r_ex_ctrl.mem_read),
    .i_ex_rt      (r_ex_rt),
    .i_id_valid   (id_valid_i),
    .i_id_alu_src (w_id_ctrl.alu_src),
    .i_id_memwrite(w_id_ctrl.memwrite),
    .i_id_branch  (w_id_ctrl.branch),
    .i_id_rs      (id_rs_i),
    .i_id_rt      (id_rt_i),
    .o_hazard     (w_hazard)
  );

  // A flush squashes the ID instruction, so it also cancels any stall it caused.
  assign stall_o  = hold_i | (w_hazard & ~flush_i);
  assign w_bubble = flush_i | w_hazard;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ex_valid   <= 1'b0;
      r_ex_ctrl    <= CTRL_BUBBLE;
      r_ex_pc4     <= '0;
      r_ex_rs_data <= '0;
      r_ex_rt_data <= '0;
      r_ex_imm     <= '0;
      r_ex_rs      <= '0;
      r_ex_rt      <= '0;
      r_ex_rd      <= '0;
    end else if (hold_i) begin
      r_ex_valid   <= r_ex_valid;
    end else if (w_bubble) begin
      r_ex_valid   <= 1'b0;
      r_ex_ctrl    <= CTRL_BUBBLE;
      r_ex_pc4     <= '0;
      r_ex_rs_data <= '0;
      r_ex_rt_data <= '0;
      r_ex_imm     <= '0;
      r_ex_rs      <= '0;
      r_ex_rt      <= '0;
      r_ex_rd      <= '0;
    end else begin
      r_ex_valid   <= id_valid_i;
      r_ex_ctrl    <= id_valid_i ? w_id_ctrl : CTRL_BUBBLE;
      r_ex_pc4     <= id_pc4_i;
      r_ex_rs_data <= id_rs_data_i;
      r_ex_rt_data <= id_rt_data_i;
      r_ex_imm     <= id_imm_i;
      r_ex_rs      <= id_rs_i;
      r_ex_rt      <= id_rt_i;
      r_ex_rd      <= id_rd_i;
    end
  end

  assign ex_valid_o   = r_ex_valid;
  assign ex_ctrl_o    = r_ex_ctrl;
  assign ex_pc4_o     = r_ex_pc4;
  assign ex_rs_data_o = r_ex_rs_data;
  assign ex_rt_data_o = r_ex_rt_data;
  assign ex_imm_o     = r_ex_imm;
  assign ex_rs_o      = r_ex_rs;
  assign ex_rt_o      = r_ex_rt;
  assign ex_rd_o      = r_ex_rd;

`ifdef ID_EX_PERF_CNT_EN
  logic             w_flush_take;
  logic             w_stall_take;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  assign w_flush_take = ~hold_i & flush_i;
  assign w_stall_take = ~hold_i & ~flush_i & w_hazard;

  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_take && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush_take && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule
